ula_multiciclo: RTL and testbench

Parametrised, multi-cycle ALU for the RISC-V datapath. It keeps the 3-bit `ULAControl` operation encoding and extends it in four ways: a configurable `WIDTH`, a valid/ready handshake, an iterative shift-add multiplier and restoring divider (high word and remainder included), and a full flag set (Z, N, C, V, divide-by-zero, illegal). It sits between the register-file read stage and writeback; the control FSM stalls on `in_ready`/`out_valid`.

---
 rtl/ula_multiciclo.sv | 200 ++++++++++++++++++++
 tb/tb_ula_multiciclo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU with valid/ready handshake and a full flag set.
// Define ULA_MULDIV_EN to build the iterative shift-add multiplier and restoring divider.
module ula_multiciclo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ULAControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ULAResult,
    output logic [WIDTH-1:0] ULAResultHi,
    output logic             FlagZ,
    output logic             FlagN,
    output logic             FlagC,
    output logic             FlagV,
    output logic             FlagDZ,
    output logic             FlagIllegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ULA_MULDIV_EN
        S_CALC = 2'd1,
`endif
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_MUL = 3'b100, OP_SLT = 3'b101, OP_DIV = 3'b110, OP_XOR = 3'b111
    } op_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_res_hi;
    logic             r_z, r_n, r_c, r_v;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v;
    logic             w_muldiv;

    // Single-cycle datapath, evaluated straight from the accepted operands.
    always_comb begin
        w_sum    = {1'b0, SrcA} + {1'b0, SrcB};
        w_diff   = {1'b0, SrcA} - {1'b0, SrcB};
        w_res    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_muldiv = (ULAControl == OP_MUL) || (ULAControl == OP_DIV);
        case (ULAControl)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (w_diff[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND:  w_res = SrcA & SrcB;
            OP_OR:   w_res = SrcA | SrcB;
            OP_XOR:  w_res = SrcA ^ SrcB;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
            default: w_res = '0;
        endcase
    end

`ifdef ULA_MULDIV_EN
    localparam int CW = $clog2(WIDTH);

    // r_hi:r_lo is the product register for MUL and remainder:quotient for DIV;
    // r_opnd holds the multiplicand (MUL) or the divisor (DIV).
    logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_dz;

    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_rshift;
    logic [WIDTH-1:0] w_rsub;
    logic             w_ge;
    logic [WIDTH-1:0] w_nhi, w_nlo;

    always_comb begin
        w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_rshift = {r_hi, r_lo[WIDTH-1]};
        w_ge     = (w_rshift >= {1'b0, r_opnd});
        w_rsub   = w_rshift[WIDTH-1:0] - r_opnd;
        if (r_is_div) begin
            w_nhi = w_ge ? w_rsub : w_rshift[WIDTH-1:0];
            w_nlo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_nhi = w_madd[WIDTH:1];
            w_nlo = {w_madd[0], r_lo[WIDTH-1:1]};
        end
    end
`else
    logic r_ill;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_res    <= '0;
            r_res_hi <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
`ifdef ULA_MULDIV_EN
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
`else
            r_ill    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
`ifdef ULA_MULDIV_EN
                    if (w_muldiv) begin
                        r_is_div <= (ULAControl == OP_DIV);
                        r_hi     <= '0;
                        r_lo     <= (ULAControl == OP_DIV) ? SrcA : SrcB;
                        r_opnd   <= (ULAControl == OP_DIV) ? SrcB : SrcA;
                        r_cnt    <= CW'(WIDTH - 1);
                        r_state  <= S_CALC;
                    end else begin
                        r_res    <= w_res;
                        r_res_hi <= '0;
                        r_z      <= (w_res == '0);
                        r_n      <= w_res[WIDTH-1];
                        r_c      <= w_c;
                        r_v      <= w_v;
                        r_dz     <= 1'b0;
                        r_state  <= S_DONE;
                    end
`else
                    r_res    <= w_res;
                    r_res_hi <= '0;
                    r_z      <= (w_res == '0);
                    r_n      <= w_res[WIDTH-1];
                    r_c      <= w_c;
                    r_v      <= w_v;
                    r_ill    <= w_muldiv;
                    r_state  <= S_DONE;
`endif
                end
`ifdef ULA_MULDIV_EN
                S_CALC: begin
                    r_hi <= w_nhi;
                    r_lo <= w_nlo;
                    if (r_cnt == '0) begin
                        r_res    <= w_nlo;
                        r_res_hi <= w_nhi;
                        r_z      <= (w_nlo == '0);
                        r_n      <= w_nlo[WIDTH-1];
                        r_c      <= 1'b0;
                        r_v      <= 1'b0;
                        r_dz     <= r_is_div && (r_opnd == '0);
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                S_DONE: if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign ULAResult   = r_res;
    assign ULAResultHi = r_res_hi;
    assign FlagZ       = r_z;
    assign FlagN       = r_n;
    assign FlagC       = r_c;
    assign FlagV       = r_v;
`ifdef ULA_MULDIV_EN
    assign FlagDZ      = r_dz;
    assign FlagIllegal = 1'b0;
`else
    assign FlagDZ      = 1'b0;
    assign FlagIllegal = r_ill;
`endif

endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomised self-checking bench for ula_multiciclo against an arithmetic reference model.
// Follows the ULA_MULDIV_EN setting of the build.
module tb_ula_multiciclo;

    localparam int W = 8;
`ifdef ULA_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic [2:0]   ULAControl = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] ULAResult, ULAResultHi;
    logic         FlagZ, FlagN, FlagC, FlagV, FlagDZ, FlagIllegal;

    ula_multiciclo #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .ULAControl(ULAControl),
        .out_valid(out_valid), .out_ready(out_ready),
        .ULAResult(ULAResult), .ULAResultHi(ULAResultHi),
        .FlagZ(FlagZ), .FlagN(FlagN), .FlagC(FlagC), .FlagV(FlagV),
        .FlagDZ(FlagDZ), .FlagIllegal(FlagIllegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic [5:0] fl;
        int         lat;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {FlagZ, FlagN, FlagC, FlagV, FlagDZ, FlagIllegal};
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int t  = 0;
        logic c = 1'b0, v = 1'b0, dz = 1'b0, ill = 1'b0;
        e.res = '0;
        e.hi  = '0;
        e.lat = 1;
        case (op)
            3'd0: begin
                t = ua + ub; e.res = t[7:0]; c = (t > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            3'd1: begin
                t = ua - ub; e.res = t[7:0]; c = (ua < ub);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd7: e.res = a ^ b;
            3'd5: e.res = (ua < ub) ? 8'd1 : 8'd0;
            3'd4: begin
                if (MD) begin
                    t = ua * ub; e.res = t[7:0]; e.hi = t[15:8]; e.lat = W + 1;
                end else ill = 1'b1;
            end
            default: begin
                if (MD) begin
                    e.lat = W + 1;
                    if (ub == 0) begin
                        e.res = 8'hFF; e.hi = a; dz = 1'b1;
                    end else begin
                        t = ua / ub; e.res = t[7:0];
                        t = ua % ub; e.hi = t[7:0];
                    end
                end else ill = 1'b1;
            end
        endcase
        e.fl = {(e.res == 8'd0), e.res[7], c, v, dz, ill};
        return e;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
        exp_t e;
        int   n;
        bit   busy_ok;
        e = model(op, a, b);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        SrcA = a; SrcB = b; ULAControl = op; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        SrcA = W'($urandom); SrcB = W'($urandom); ULAControl = 3'($urandom);
        n = 1;
        busy_ok = 1'b1;
        while (!out_valid && n < 4 * W) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("latency op%0d", op), n, e.lat);
        if (e.lat > 1) chk("in_ready_busy", busy_ok, 1);
        chk($sformatf("result op%0d %0d,%0d", op, a, b), ULAResult, e.res);
        chk($sformatf("result_hi op%0d %0d,%0d", op, a, b), ULAResultHi, e.hi);
        chk($sformatf("flags op%0d %0d,%0d", op, a, b), flags(), e.fl);
        chk("in_ready_done", in_ready, 0);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("held", {out_valid, in_ready, ULAResult, ULAResultHi, flags()},
                {1'b1, 1'b0, e.res, e.hi, e.fl});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release", {out_valid, in_ready}, 2'b01);
        out_ready = 1'b0;
    endtask

    task automatic throughput();
        exp_t          e;
        int            cnt = 0;
        logic [7:0]    a = 8'($urandom);
        logic [7:0]    b = 8'($urandom);
        e = model(3'd0, a, b);
        @(negedge clk);
        SrcA = a; SrcB = b; ULAControl = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) begin
                cnt++;
                chk("thru_result", ULAResult, e.res);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("throughput_count", cnt, 5);
    endtask

    task automatic reset_abort();
        bit quiet = 1'b1;
        @(negedge clk);
        SrcA = 8'd25; SrcB = 8'd20; ULAControl = 3'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_abort", {out_valid, in_ready, ULAResult, ULAResultHi, flags()},
            {1'b0, 1'b1, 8'h00, 8'h00, 6'h00});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (out_valid) quiet = 1'b0;
        end
        chk("no_result_after_rst", quiet, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {out_valid, in_ready, ULAResult, ULAResultHi, flags()},
            {1'b0, 1'b1, 8'h00, 8'h00, 6'h00});
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 8'd200, 8'd100, 0);
        run_op(3'd0, 8'd100, 8'd100, 0);
        run_op(3'd1, 8'd5,   8'd5,   0);
        run_op(3'd1, 8'd3,   8'd5,   0);
        run_op(3'd5, 8'd3,   8'd5,   0);
        run_op(3'd5, 8'd5,   8'd3,   0);
        run_op(3'd4, 8'd25,  8'd20,  0);
        run_op(3'd6, 8'd200, 8'd7,   0);
        run_op(3'd6, 8'd13,  8'd0,   0);
        run_op(3'd4, 8'd3,   8'd4,   0);
        run_op(3'd4, 8'd255, 8'd255, 5);
        run_op(3'd2, 8'hF0,  8'h3C,  0);
        run_op(3'd0, 8'd77,  8'd99,  5);
        run_op(3'd7, 8'hA5,  8'h5A,  0);
        run_op(3'd6, 8'd255, 8'd1,   0);
        run_op(3'd6, 8'd5,   8'd255, 0);
        run_op(3'd6, 8'd0,   8'd0,   0);
        run_op(3'd1, 8'h80,  8'h01,  0);

        for (int i = 0; i < 150; i++)
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 2));

        throughput();
        reset_abort();
        run_op(3'd0, 8'd200, 8'd100, 0);
        run_op(3'd3, 8'h12,  8'h81,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
